// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage types and constants; ifid_t is also the IF/ID record consumed by decode.
package fetch_stage_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
   localparam logic [31:0] PC_INCR          = 32'd4;

   typedef enum logic {
      RUN  = 1'b0,
      HOLD = 1'b1
   } fetch_state_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] pc4;
      logic [31:0] instr;
   } ifid_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory port between the fetch stage (master) and a stateless memory (slave).
interface fetch_stage_if;

   // A beat completes in any cycle where imem_req=1 and imem_ack=1; imem_rdata is
   // meaningful only in that cycle. The slave keeps no state, so imem_addr may
   // change freely while imem_ack=0.
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );

endinterface

// File: rtl/fetch_stage_yadder.sv
// 32-bit ripple-carry adder shared across the CPU datapath.
module yAdder (
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   input  logic        i_cin,
   output logic [31:0] o_sum,
   output logic        o_cout
);

   logic w_c;

   always_comb begin
      o_sum = '0;
      w_c   = i_cin;
      for (int i = 0; i < 32; i++) begin
         o_sum[i] = i_a[i] ^ i_b[i] ^ w_c;
         w_c      = (i_a[i] & i_b[i]) | (w_c & (i_a[i] ^ i_b[i]));
      end
      o_cout = w_c;
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, memory request, one-entry skid buffer and IF/ID register.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = fetch_stage_pkg::RESET_PC_DEFAULT,
   parameter logic [31:0] NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          stall_i,
   input  logic                          redirect_i,
   input  logic [31:0]                   redirect_pc_i,
   fetch_stage_if.master                 imem,
   output logic                          ifid_valid_o,
   output logic [31:0]                   ifid_pc_o,
   output logic [31:0]                   ifid_pc4_o,
   output logic [31:0]                   ifid_instr_o,
   output fetch_stage_pkg::fetch_state_t dbg_state_o
);

   import fetch_stage_pkg::*;

   localparam ifid_t IFID_EMPTY = '{valid: 1'b0, pc: 32'h0, pc4: 32'h0, instr: NOP_INSTR};

   fetch_state_t r_state, w_state_next;
   ifid_t        r_ifid, w_ifid_next;
   ifid_t        r_skid, w_skid_next;
   logic [31:0]  r_pc, w_pc_next;
   logic [31:0]  w_pc4;
   logic         w_cout_unused;
   logic         w_unused;
   logic         w_beat;

   yAdder u_pc_adder (
      .i_a    (r_pc),
      .i_b    (PC_INCR),
      .i_cin  (1'b0),
      .o_sum  (w_pc4),
      .o_cout (w_cout_unused)
   );

   // Carry-out is meaningless for PC wrap; redirect targets are word aligned.
   assign w_unused = ^{w_cout_unused, redirect_pc_i[1:0]};

   assign imem.imem_req  = (r_state == RUN);
   assign imem.imem_addr = r_pc;
   assign w_beat         = imem.imem_req & imem.imem_ack;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= RUN;
         r_pc    <= RESET_PC;
         r_ifid  <= IFID_EMPTY;
         r_skid  <= IFID_EMPTY;
      end else begin
         r_state <= w_state_next;
         r_pc    <= w_pc_next;
         r_ifid  <= w_ifid_next;
         r_skid  <= w_skid_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_pc_next    = r_pc;
      w_ifid_next  = r_ifid;
      w_skid_next  = r_skid;

      if (redirect_i) begin
         // Anything acked this cycle belongs to the wrong path and is dropped.
         w_state_next      = RUN;
         w_pc_next         = {redirect_pc_i[31:2], 2'b00};
         w_ifid_next.valid = 1'b0;
         w_ifid_next.instr = NOP_INSTR;
         w_skid_next       = IFID_EMPTY;
      end else begin
         unique case (r_state)
            RUN: begin
               if (w_beat && !stall_i) begin
                  w_ifid_next = '{valid: 1'b1, pc: r_pc, pc4: w_pc4, instr: imem.imem_rdata};
                  w_pc_next   = w_pc4;
               end else if (w_beat && stall_i) begin
                  w_skid_next  = '{valid: 1'b1, pc: r_pc, pc4: w_pc4, instr: imem.imem_rdata};
                  w_pc_next    = w_pc4;
                  w_state_next = HOLD;
               end else if (!stall_i) begin
                  w_ifid_next.valid = 1'b0;
                  w_ifid_next.instr = NOP_INSTR;
               end
            end
            HOLD: begin
               if (!stall_i) begin
                  w_ifid_next  = r_skid;
                  w_skid_next  = IFID_EMPTY;
                  w_state_next = RUN;
               end
            end
            default: w_state_next = RUN;
         endcase
      end
   end

   assign ifid_valid_o = r_ifid.valid;
   assign ifid_pc_o    = r_ifid.pc;
   assign ifid_pc4_o   = r_ifid.pc4;
   assign ifid_instr_o = r_ifid.instr;
   assign dbg_state_o  = r_state;

endmodule

// File: tb/tb_fetch_stage.sv
// Fetch-stage bench: directed scenarios then random stall/ack/redirect/reset against a queue model.
module tb_fetch_stage;
   import fetch_stage_pkg::*;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
   endfunction

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0;
   logic        redir = 1'b0;
   logic [31:0] rpc = 32'h0;
   logic        ack = 1'b0;

   logic         ifid_valid;
   logic [31:0]  ifid_pc, ifid_pc4, ifid_instr;
   fetch_state_t dbg_state;

   always #5 clk = ~clk;

   fetch_stage_if bus ();
   assign bus.imem_ack   = ack;
   assign bus.imem_rdata = mem_word(bus.imem_addr);

   fetch_stage dut (
      .clk           (clk),
      .reset         (reset),
      .stall_i       (stall),
      .redirect_i    (redir),
      .redirect_pc_i (rpc),
      .imem          (bus.master),
      .ifid_valid_o  (ifid_valid),
      .ifid_pc_o     (ifid_pc),
      .ifid_pc4_o    (ifid_pc4),
      .ifid_instr_o  (ifid_instr),
      .dbg_state_o   (dbg_state)
   );

   int n_vec = 0;
   int n_err = 0;

   // Model: fetched-but-not-delivered instructions {pc, pc4, instr}; at most one.
   logic [95:0] exp_q[$];
   logic [31:0] m_pc;
   logic        e_valid;
   logic [31:0] e_pc, e_pc4, e_instr;
   logic        e_chk_pc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_pc     = 32'h0;
      e_valid  = 1'b0;
      e_pc     = 32'h0;
      e_pc4    = 32'h0;
      e_instr  = 32'h0;
      e_chk_pc = 1'b1;
   endtask

   task automatic step(input logic rs, input logic st, input logic rd,
                       input logic [31:0] tp, input logic ak);
      logic [95:0] ent;
      @(negedge clk);
      reset = rs; stall = st; redir = rd; rpc = tp; ack = ak;
      #1;
      chk("imem_req", {31'b0, bus.imem_req}, {31'b0, (exp_q.size() == 0)});
      chk("imem_addr", bus.imem_addr, m_pc);
      @(posedge clk);
      e_chk_pc = 1'b0;
      if (rs) begin
         model_reset();
      end else if (rd) begin
         exp_q.delete();
         m_pc    = {tp[31:2], 2'b00};
         e_valid = 1'b0;
         e_instr = 32'h0;
      end else begin
         if (exp_q.size() == 0 && ak) begin
            exp_q.push_back({m_pc, m_pc + 32'd4, mem_word(m_pc)});
            m_pc = m_pc + 32'd4;
         end
         if (!st) begin
            if (exp_q.size() > 0) begin
               ent = exp_q.pop_front();
               e_valid = 1'b1;
               {e_pc, e_pc4, e_instr} = ent;
            end else begin
               e_valid = 1'b0;
               e_instr = 32'h0;
            end
         end
      end
      #1;
      chk("ifid_valid", {31'b0, ifid_valid}, {31'b0, e_valid});
      chk("ifid_instr", ifid_instr, e_instr);
      if (e_valid || e_chk_pc) begin
         chk("ifid_pc", ifid_pc, e_pc);
         chk("ifid_pc4", ifid_pc4, e_pc4);
      end
      chk("state", {31'b0, dbg_state}, {31'b0, (exp_q.size() != 0)});
   endtask

   initial begin
      // Clock/reset
      reset = 1'b1;
      repeat (2) @(posedge clk);
      model_reset();
      #1;
      chk("rst_valid", {31'b0, ifid_valid}, 32'h0);
      chk("rst_pc", ifid_pc, 32'h0);
      chk("rst_pc4", ifid_pc4, 32'h0);
      chk("rst_instr", ifid_instr, 32'h0);
      chk("rst_req", {31'b0, bus.imem_req}, 32'h1);
      chk("rst_addr", bus.imem_addr, 32'h0);

      // Streaming fetch, no stall
      step(0, 0, 0, 0, 1);
      chk("seq_pc0", ifid_pc, 32'h0);
      step(0, 0, 0, 0, 1);
      chk("seq_pc1", ifid_pc, 32'h4);
      step(0, 0, 0, 0, 1);
      chk("seq_pc2", ifid_pc, 32'h8);
      step(0, 0, 0, 0, 1);

      // Ack at 0x10 while stalled for three cycles
      step(0, 1, 0, 0, 1);
      chk("hold_req", {31'b0, bus.imem_req}, 32'h0);
      chk("hold_ifid_pc", ifid_pc, 32'hC);
      step(0, 1, 0, 0, 1);
      step(0, 1, 0, 0, 1);
      step(0, 0, 0, 0, 0);
      chk("release_pc", ifid_pc, 32'h10);
      chk("release_instr", ifid_instr, mem_word(32'h10));
      step(0, 0, 0, 0, 1);
      chk("after_release_pc", ifid_pc, 32'h14);

      // Redirect while in HOLD with stall asserted
      step(0, 1, 0, 0, 1);
      step(0, 1, 1, 32'h0000_0103, 1);
      chk("redir_valid", {31'b0, ifid_valid}, 32'h0);
      chk("redir_addr", bus.imem_addr, 32'h100);
      chk("redir_state", {31'b0, dbg_state}, 32'h0);
      step(0, 0, 0, 0, 1);
      chk("redir_first_pc", ifid_pc, 32'h100);

      // Two un-acked cycles give two bubbles
      step(0, 0, 0, 0, 0);
      chk("bubble0_instr", ifid_instr, 32'h0);
      step(0, 0, 0, 0, 0);
      chk("bubble1_addr", bus.imem_addr, 32'h104);
      step(0, 0, 0, 0, 1);
      chk("bubble_resume_pc", ifid_pc, 32'h104);

      // PC wrap at the top of the address space
      step(0, 0, 1, 32'hFFFF_FFFC, 1);
      step(0, 0, 0, 0, 1);
      chk("wrap_pc", ifid_pc, 32'hFFFF_FFFC);
      chk("wrap_pc4", ifid_pc4, 32'h0);
      chk("wrap_addr", bus.imem_addr, 32'h0);

      // Reset in HOLD, and reset coinciding with redirect
      step(0, 1, 0, 0, 1);
      step(1, 1, 0, 0, 1);
      chk("rst_hold_addr", bus.imem_addr, 32'h0);
      step(0, 1, 0, 0, 1);
      step(1, 0, 1, 32'h40, 1);
      chk("rst_redir_addr", bus.imem_addr, 32'h0);
      step(0, 0, 0, 0, 0);
      chk("no_stale_valid", {31'b0, ifid_valid}, 32'h0);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 99) < 1),
              ($urandom_range(0, 99) < 30),
              ($urandom_range(0, 99) < 5),
              $urandom(),
              ($urandom_range(0, 99) < 70));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
